// File: rtl/aux_capture_if.sv
// rtl/aux_capture_if.sv - write side of the 25-bit aux send FIFO
interface aux_capture_if;
  logic [24:0] fifo_din;
  logic        fifo_wr_en;
  logic        fifo_full;

  modport master (output fifo_din, output fifo_wr_en, input fifo_full);
  modport slave  (input fifo_din, input fifo_wr_en, output fifo_full);
endinterface

// File: rtl/aux_capture.sv
// rtl/aux_capture.sv - captures TERC4 aux data-island bursts into the aux send FIFO
module aux_capture #(
  parameter int BURST_LEN = 32,
  parameter int NUM_W     = 4
) (
  input  logic             fifo_clk,
  input  logic             sys_rst,
  input  logic             vde,
  input  logic             ade,
  input  logic [3:0]       aux0,
  input  logic [3:0]       aux1,
  input  logic [3:0]       aux2,
  aux_capture_if.master    fifo,
  output logic [NUM_W-1:0] ade_num,
  output logic             ade_num_vld,
  output logic             overflow,
  output logic             short_burst
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, BURST, DROP} state_t;

  state_t           state_q;
  logic [15:0]      pos_q;
  logic [15:0]      pos_d;
  logic [15:0]      pos_nxt;
  logic             ade_d;
  logic             aux0_b2_d;
  logic [3:0]       aux1_d;
  logic [3:0]       aux2_d;
  logic             vde_q;
  logic             armed_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [NUM_W-1:0] burst_cnt_q;
  logic [NUM_W-1:0] burst_cnt_inc;
  logic [NUM_W-1:0] ade_num_q;
  logic             ade_num_vld_q;
  logic             overflow_q;
  logic             short_q;
  logic             cap;
  logic             start;
  logic             last;
  logic             vde_rise;
  logic             unused_aux0;

  // Only the TERC4 bit carrying the packet header is kept from channel 0.
  assign unused_aux0 = ^{aux0[3], aux0[1:0]};

  assign pos_nxt       = vde ? 16'd0 : ((pos_q == 16'hFFFF) ? pos_q : pos_q + 16'd1);
  // vde_q is the vde of the same sampled cycle as ade_d, so it blocks that word.
  assign cap           = ade_d & ~vde_q;
  assign start         = cap & armed_q & (state_q == IDLE);
  assign last          = (word_cnt_q == LAST);
  assign vde_rise      = vde & ~vde_q;
  assign burst_cnt_inc = (burst_cnt_q == {NUM_W{1'b1}}) ? burst_cnt_q : burst_cnt_q + NUM_W'(1);

  assign fifo.fifo_wr_en = cap & ~fifo.fifo_full &
                           (((state_q == IDLE) & armed_q) | (state_q == BURST));
  assign fifo.fifo_din   = {pos_d, aux2_d, aux1_d, aux0_b2_d};

  assign ade_num     = ade_num_q;
  assign ade_num_vld = ade_num_vld_q;
  assign overflow    = overflow_q;
  assign short_burst = short_q;

  always_ff @(posedge fifo_clk) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      pos_q         <= '0;
      pos_d         <= '0;
      ade_d         <= 1'b0;
      aux0_b2_d     <= 1'b0;
      aux1_d        <= '0;
      aux2_d        <= '0;
      vde_q         <= 1'b0;
      armed_q       <= 1'b0;
      word_cnt_q    <= '0;
      burst_cnt_q   <= '0;
      ade_num_q     <= '0;
      ade_num_vld_q <= 1'b0;
      overflow_q    <= 1'b0;
      short_q       <= 1'b0;
    end else begin
      pos_q     <= pos_nxt;
      pos_d     <= pos_nxt;
      ade_d     <= ade;
      aux0_b2_d <= aux0[2];
      aux1_d    <= aux1;
      aux2_d    <= aux2;
      vde_q     <= vde;
      if (vde) begin
        armed_q <= 1'b1;
      end

      // A burst starting on the vde rising edge belongs to the new interval.
      ade_num_vld_q <= vde_rise;
      if (vde_rise) begin
        ade_num_q   <= burst_cnt_q;
        burst_cnt_q <= start ? NUM_W'(1) : '0;
      end else if (start) begin
        burst_cnt_q <= burst_cnt_inc;
      end

      if (vde_q) begin
        state_q    <= IDLE;
        word_cnt_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              word_cnt_q <= CNT_W'(1);
              if (fifo.fifo_full) begin
                state_q    <= DROP;
                overflow_q <= 1'b1;
              end else begin
                state_q <= BURST;
              end
            end
          end
          BURST: begin
            if (!ade_d) begin
              state_q    <= IDLE;
              word_cnt_q <= '0;
              short_q    <= 1'b1;
            end else if (last) begin
              state_q    <= IDLE;
              word_cnt_q <= '0;
              if (fifo.fifo_full) begin
                overflow_q <= 1'b1;
              end
            end else begin
              word_cnt_q <= word_cnt_q + CNT_W'(1);
              if (fifo.fifo_full) begin
                state_q    <= DROP;
                overflow_q <= 1'b1;
              end
            end
          end
          DROP: begin
            if (!ade_d || last) begin
              state_q    <= IDLE;
              word_cnt_q <= '0;
            end else begin
              word_cnt_q <= word_cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aux_capture.sv
// tb/tb_aux_capture.sv - directed bench for aux_capture with a run-length reference model
module tb_aux_capture;

  localparam int BL    = 32;
  localparam int NUM_W = 4;

  logic             fifo_clk;
  logic             sys_rst;
  logic             vde;
  logic             ade;
  logic [3:0]       aux0;
  logic [3:0]       aux1;
  logic [3:0]       aux2;
  logic [NUM_W-1:0] ade_num;
  logic             ade_num_vld;
  logic             overflow;
  logic             short_burst;

  aux_capture_if fifo_if ();

  aux_capture #(.BURST_LEN(BL), .NUM_W(NUM_W)) dut (
    .fifo_clk   (fifo_clk),
    .sys_rst    (sys_rst),
    .vde        (vde),
    .ade        (ade),
    .aux0       (aux0),
    .aux1       (aux1),
    .aux2       (aux2),
    .fifo       (fifo_if),
    .ade_num    (ade_num),
    .ade_num_vld(ade_num_vld),
    .overflow   (overflow),
    .short_burst(short_burst)
  );

  initial begin
    fifo_clk = 1'b0;
    forever #5 fifo_clk = ~fifo_clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Reference model: a capture run is a stretch of sampled cycles with ade=1, vde=0
  // after arming; word k of the run belongs to burst k/BL at slot k%BL.
  bit          m_ok = 1'b0;
  logic        a_p, v_p;
  logic [3:0]  x0_p, x1_p, x2_p;
  int          pos_p;
  bit          armed_m;
  int          run_len;
  bit          dropped;
  int          cnt_m;
  int          e_num;
  bit          e_vld, e_ovf, e_short;

  logic [24:0] wr_log[$];
  int          nvld = 0;
  int          last_num = -1;

  always @(negedge fifo_clk) begin
    bit          cap, new_burst, drop_eff, wr, vr;
    logic [24:0] e_din;
    #1;
    cap       = armed_m && a_p && !v_p;
    new_burst = cap && ((run_len % BL) == 0);
    drop_eff  = new_burst ? 1'b0 : dropped;
    wr        = cap && !drop_eff && !fifo_if.fifo_full;
    e_din     = {pos_p[15:0], x2_p, x1_p, x0_p[2]};
    if (m_ok) begin
      chk("wr_en", {31'd0, fifo_if.fifo_wr_en}, {31'd0, wr});
      chk("din", {7'd0, fifo_if.fifo_din}, {7'd0, e_din});
      chk("ade_num", {28'd0, ade_num}, e_num);
      chk("ade_num_vld", {31'd0, ade_num_vld}, {31'd0, e_vld});
      chk("overflow", {31'd0, overflow}, {31'd0, e_ovf});
      chk("short_burst", {31'd0, short_burst}, {31'd0, e_short});
      if (fifo_if.fifo_wr_en === 1'b1) wr_log.push_back(fifo_if.fifo_din);
      if (ade_num_vld === 1'b1) begin
        nvld++;
        last_num = int'(ade_num);
      end
    end

    if (cap) begin
      if (!drop_eff && fifo_if.fifo_full) e_ovf = 1'b1;
      dropped = drop_eff || fifo_if.fifo_full;
      run_len++;
    end else begin
      if (run_len > 0 && !v_p && (run_len % BL) != 0 && !dropped) e_short = 1'b1;
      run_len = 0;
    end
    vr    = vde && !v_p;
    e_vld = vr;
    if (vr) begin
      e_num = cnt_m;
      cnt_m = new_burst ? 1 : 0;
    end else if (new_burst) begin
      cnt_m = (cnt_m + 1 > (1 << NUM_W) - 1) ? (1 << NUM_W) - 1 : cnt_m + 1;
    end
    if (vde) armed_m = 1'b1;
    pos_p = vde ? 0 : ((pos_p == 65535) ? pos_p : pos_p + 1);
    a_p   = ade;
    v_p   = vde;
    x0_p  = aux0;
    x1_p  = aux1;
    x2_p  = aux2;

    if (sys_rst) begin
      m_ok    = 1'b1;
      a_p     = 1'b0;
      v_p     = 1'b0;
      x0_p    = '0;
      x1_p    = '0;
      x2_p    = '0;
      pos_p   = 0;
      armed_m = 1'b0;
      run_len = 0;
      dropped = 1'b0;
      cnt_m   = 0;
      e_num   = 0;
      e_vld   = 1'b0;
      e_ovf   = 1'b0;
      e_short = 1'b0;
    end
  end

  task automatic drive(input logic r, input logic v, input logic a,
                       input logic [3:0] x2, input logic [3:0] x1, input logic [3:0] x0,
                       input logic f);
    @(negedge fifo_clk);
    sys_rst           = r;
    vde               = v;
    ade               = a;
    aux2              = x2;
    aux1              = x1;
    aux0              = x0;
    fifo_if.fifo_full = f;
  endtask

  task automatic idle(input int n, input logic v);
    repeat (n) drive(1'b0, v, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic burst(input int n, input logic [3:0] x2, input logic [3:0] x1,
                       input logic [3:0] x0, input bit vary);
    for (int j = 0; j < n; j++) begin
      if (vary) drive(1'b0, 1'b0, 1'b1, 4'(j), 4'(j * 3), 4'(j * 5), 1'b0);
      else      drive(1'b0, 1'b0, 1'b1, x2, x1, x0, 1'b0);
    end
  endtask

  initial begin
    int          base;
    int          v0;
    bit          ok;
    logic [24:0] first_exp;

    sys_rst           = 1'b1;
    vde               = 1'b0;
    ade               = 1'b0;
    aux0              = '0;
    aux1              = '0;
    aux2              = '0;
    fifo_if.fifo_full = 1'b0;
    repeat (3) drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    #1;
    chk("rst_wr_en", {31'd0, fifo_if.fifo_wr_en}, 32'd0);
    chk("rst_din", {7'd0, fifo_if.fifo_din}, 32'd0);
    chk("rst_ade_num", {28'd0, ade_num}, 32'd0);
    chk("rst_flags", {30'd0, overflow, short_burst}, 32'd0);

    // ade before any vde is ignored
    repeat (2) begin
      burst(5, 4'h1, 4'h2, 4'h3, 1'b1);
      idle(3, 1'b0);
    end
    idle(2, 1'b0);
    chk("unarmed_writes", wr_log.size(), 32'd0);
    chk("unarmed_ade_num", {28'd0, ade_num}, 32'd0);

    // single burst: first word at pos 11 after 10 idle clocks
    idle(4, 1'b1);
    idle(10, 1'b0);
    base = wr_log.size();
    burst(BL, 4'hA, 4'h5, 4'h4, 1'b0);
    idle(3, 1'b0);
    first_exp = {16'd11, 4'hA, 4'h5, 1'b1};
    chk("burst1_count", wr_log.size() - base, 32'd32);
    chk("burst1_first", {7'd0, wr_log[base]}, {7'd0, first_exp});
    chk("burst1_last_pos", {16'd0, wr_log[base + 31][24:9]}, 32'd42);
    ok = 1'b1;
    for (int i = base; i < base + 31; i++)
      if (wr_log[i + 1][24:9] != wr_log[i][24:9] + 16'd1) ok = 1'b0;
    chk("burst1_pos_step", {31'd0, ok}, 32'd1);
    idle(3, 1'b1);
    chk("interval1_num", last_num, 32'd1);

    // three back-to-back bursts
    idle(4, 1'b0);
    base = wr_log.size();
    v0   = nvld;
    burst(3 * BL, 4'h0, 4'h0, 4'h0, 1'b1);
    idle(3, 1'b0);
    idle(5, 1'b1);
    chk("b2b_count", wr_log.size() - base, 32'd96);
    chk("b2b_num", last_num, 32'd3);
    chk("b2b_vld_pulses", nvld - v0, 32'd1);

    // fifo_full from word 10 until after the burst
    idle(4, 1'b0);
    base = wr_log.size();
    for (int j = 0; j < 40; j++)
      drive(1'b0, 1'b0, j < BL, 4'h3, 4'hC, 4'h4, (j >= 10 && j < 34));
    chk("full_count", wr_log.size() - base, 32'd9);
    chk("full_overflow", {31'd0, overflow}, 32'd1);
    idle(3, 1'b0);
    base = wr_log.size();
    burst(BL, 4'h0, 4'h0, 4'h0, 1'b1);
    idle(3, 1'b0);
    chk("after_full_count", wr_log.size() - base, 32'd32);

    // short burst
    base = wr_log.size();
    burst(20, 4'h0, 4'h0, 4'h0, 1'b1);
    idle(3, 1'b0);
    chk("short_count", wr_log.size() - base, 32'd20);
    chk("short_flag", {31'd0, short_burst}, 32'd1);
    idle(3, 1'b1);
    chk("interval3_num", last_num, 32'd3);

    // counter saturation
    idle(3, 1'b0);
    burst(18 * BL, 4'h0, 4'h0, 4'h0, 1'b1);
    idle(3, 1'b0);
    idle(3, 1'b1);
    chk("sat_num", last_num, 32'd15);

    // burst start on the vde rising edge, then ade held under vde
    idle(3, 1'b0);
    base = wr_log.size();
    drive(1'b0, 1'b0, 1'b1, 4'h7, 4'h7, 4'h7, 1'b0);
    repeat (3) drive(1'b0, 1'b1, 1'b1, 4'h7, 4'h7, 4'h7, 1'b0);
    chk("edge_rise_num", last_num, 32'd0);
    idle(3, 1'b0);
    chk("edge_count", wr_log.size() - base, 32'd1);
    idle(3, 1'b1);
    chk("edge_next_num", last_num, 32'd1);

    // reset mid-burst disarms capture
    idle(3, 1'b0);
    base = wr_log.size();
    burst(6, 4'h0, 4'h0, 4'h0, 1'b1);
    repeat (2) drive(1'b1, 1'b0, 1'b1, 4'h1, 4'h1, 4'h1, 1'b0);
    burst(6, 4'h0, 4'h0, 4'h0, 1'b1);
    idle(3, 1'b0);
    chk("rst_mid_count", wr_log.size() - base, 32'd6);
    chk("rst_mid_flags", {30'd0, overflow, short_burst}, 32'd0);
    chk("rst_mid_num", {28'd0, ade_num}, 32'd0);
    idle(2, 1'b1);
    idle(2, 1'b0);
    base = wr_log.size();
    burst(BL, 4'h0, 4'h0, 4'h0, 1'b1);
    idle(3, 1'b0);
    chk("rearm_count", wr_log.size() - base, 32'd32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
